mult_div_unit: RTL and testbench

Iterative multiply/divide unit with HI/LO result registers for the CPU datapath, parametrised in operand width. The control unit issues MULT/MULTU/DIV/DIVU, and the unit computes over multiple cycles while asserting `busy`; the control unit stalls any HI/LO read until `done`. MTHI/MTLO writes go directly into HI/LO.

---
 rtl/mult_div_unit.sv | 156 +++++++++++++++
 tb/tb_mult_div_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand0,
    input  logic [WIDTH-1:0] operand1,
    input  logic             hi_wren,
    input  logic             lo_wren,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LastIter = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               div_by_zero_q, div_by_zero_d;

    logic [WIDTH-1:0]   mag0, mag1;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_top, div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quot, rem;
    logic [2*WIDTH-1:0] prod_neg;

    // Signed ops work on magnitudes; signs are reapplied in FIX
    assign mag0 = (op[0] && operand0[WIDTH-1]) ? -operand0 : operand0;
    assign mag1 = (op[0] && operand1[WIDTH-1]) ? -operand1 : operand1;

    // Multiply step: acc = {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                               : {1'b0, acc_q[2*WIDTH-1:1]};

    // Divide step: acc = {remainder, remaining dividend bits / quotient bits}
    assign div_top  = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff = div_top - {1'b0, opb_q};
    assign div_ge   = (div_top >= {1'b0, opb_q});
    assign div_rem  = div_ge ? div_diff[WIDTH-1:0] : div_top[WIDTH-1:0];
    assign div_next = {div_rem, acc_q[WIDTH-2:0], div_ge};

    assign quot     = acc_q[WIDTH-1:0];
    assign rem      = acc_q[2*WIDTH-1:WIDTH];
    assign prod_neg = -acc_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        opb_d         = opb_q;
        is_div_d      = is_div_q;
        neg_res_d     = neg_res_q;
        neg_rem_d     = neg_rem_q;
        dbz_d         = dbz_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        done_d        = 1'b0;
        div_by_zero_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (hi_wren) hi_d = wdata;
                if (lo_wren) lo_d = wdata;
                if (start) begin
                    is_div_d  = op[1];
                    neg_res_d = op[0] & (operand0[WIDTH-1] ^ operand1[WIDTH-1]);
                    neg_rem_d = op[0] & operand0[WIDTH-1];
                    acc_d     = {{WIDTH{1'b0}}, mag0};
                    opb_d     = mag1;
                    cnt_d     = '0;
                    dbz_d     = op[1] && (operand1 == '0);
                    state_d   = (op[1] && (operand1 == '0)) ? StFix : StCalc;
                end
            end
            StCalc: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LastIter) state_d = StFix;
            end
            StFix: begin
                done_d  = 1'b1;
                state_d = StIdle;
                if (dbz_q) begin
                    div_by_zero_d = 1'b1;
                end else if (is_div_q) begin
                    lo_d = neg_res_q ? -quot : quot;
                    hi_d = neg_rem_q ? -rem : rem;
                end else begin
                    {hi_d, lo_d} = neg_res_q ? prod_neg : acc_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            acc_q         <= '0;
            opb_q         <= '0;
            is_div_q      <= 1'b0;
            neg_res_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            dbz_q         <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            opb_q         <= opb_d;
            is_div_q      <= is_div_d;
            neg_res_q     <= neg_res_d;
            neg_rem_q     <= neg_rem_d;
            dbz_q         <= dbz_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            done_q        <= done_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign div_by_zero = div_by_zero_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit at WIDTH=32 plus a randomised WIDTH=8 instance
// checked against an integer reference model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, hi_wren, lo_wren;
    logic [1:0]  op;
    logic [31:0] operand0, operand1, wdata, hi, lo;
    logic        busy, done, div_by_zero;

    logic        start8, hi_wren8, lo_wren8;
    logic [1:0]  op8;
    logic [7:0]  operand0_8, operand1_8, wdata8, hi8, lo8;
    logic        busy8, done8, div_by_zero8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .operand0(operand0), .operand1(operand1),
        .hi_wren(hi_wren), .lo_wren(lo_wren), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    mult_div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8),
        .operand0(operand0_8), .operand1(operand1_8),
        .hi_wren(hi_wren8), .lo_wren(lo_wren8), .wdata(wdata8),
        .busy(busy8), .done(done8), .div_by_zero(div_by_zero8), .hi(hi8), .lo(lo8)
    );

    // Issue one operation on the 32-bit unit and wait (bounded) for done.
    // Entered and left at #1 after a rising edge; lat counts cycles from the start cycle.
    task automatic run32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cnt, output logic dbz_seen,
                         output logic overlap);
        start = 1'b1; op = o; operand0 = a; operand1 = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1; busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        dbz_seen = div_by_zero;
        overlap  = busy && done;
    endtask

    task automatic test_reset;
        #2;
        n_cmp++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            n_err++; $display("FAIL reset_flags: got %b expected 000", {busy, done, div_by_zero});
        end
        n_cmp++;
        if ({hi, lo} !== 64'h0) begin
            n_err++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo});
        end
        n_cmp++;
        if ({hi8, lo8, busy8} !== 17'h0) begin
            n_err++; $display("FAIL reset_w8: got %h expected 0", {hi8, lo8, busy8});
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_mult;
        int lat, bc; logic dz, ov;
        run32(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, dz, ov);
        n_cmp++;
        if (lat !== 34) begin n_err++; $display("FAIL multu_latency: got %0d expected 34", lat); end
        n_cmp++;
        if (bc !== 33) begin n_err++; $display("FAIL multu_busy_cycles: got %0d expected 33", bc); end
        n_cmp++;
        if (ov !== 1'b0) begin n_err++; $display("FAIL busy_done_overlap: got %b expected 0", ov); end
        n_cmp++;
        if (dz !== 1'b0) begin n_err++; $display("FAIL multu_dbz: got %b expected 0", dz); end
        n_cmp++;
        if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
            n_err++; $display("FAIL multu_result: got %h expected fffffffe00000001", {hi, lo});
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL done_one_cycle: got %b expected 0", done); end
        run32(2'b01, 32'hFFFF_FFFD, 32'd5, lat, bc, dz, ov);
        n_cmp++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
            n_err++; $display("FAIL mult_neg: got %h expected fffffffffffffff1", {hi, lo});
        end
    endtask

    task automatic test_div_signed;
        int lat, bc; logic dz, ov;
        run32(2'b11, 32'hFFFF_FFF9, 32'd2, lat, bc, dz, ov);
        n_cmp++;
        if (lat !== 34) begin n_err++; $display("FAIL div_latency: got %0d expected 34", lat); end
        n_cmp++;
        if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
            n_err++; $display("FAIL div_m7_2: got %h expected ffffffff_fffffffd", {hi, lo});
        end
        run32(2'b11, 32'd7, 32'hFFFF_FFFE, lat, bc, dz, ov);
        n_cmp++;
        if ({hi, lo} !== {32'h0000_0001, 32'hFFFF_FFFD}) begin
            n_err++; $display("FAIL div_7_m2: got %h expected 00000001_fffffffd", {hi, lo});
        end
        run32(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, dz, ov);
        n_cmp++;
        if ({hi, lo, dz} !== {32'h0, 32'h8000_0000, 1'b0}) begin
            n_err++; $display("FAIL div_minneg: got %h expected 00000000_80000000_0", {hi, lo, dz});
        end
    endtask

    task automatic test_div_by_zero;
        int lat, bc; logic dz, ov;
        hi_wren = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1;
        hi_wren = 1'b0;
        n_cmp++;
        if (hi !== 32'h1234) begin n_err++; $display("FAIL mthi: got %h expected 1234", hi); end
        lo_wren = 1'b1; wdata = 32'h5678;
        @(posedge clk); #1;
        lo_wren = 1'b0;
        n_cmp++;
        if (lo !== 32'h5678) begin n_err++; $display("FAIL mtlo: got %h expected 5678", lo); end
        run32(2'b10, 32'd100, 32'd0, lat, bc, dz, ov);
        n_cmp++;
        if (lat !== 2) begin n_err++; $display("FAIL dbz_latency: got %0d expected 2", lat); end
        n_cmp++;
        if (bc !== 1) begin n_err++; $display("FAIL dbz_busy_cycles: got %0d expected 1", bc); end
        n_cmp++;
        if (dz !== 1'b1) begin n_err++; $display("FAIL dbz_flag: got %b expected 1", dz); end
        n_cmp++;
        if ({hi, lo} !== {32'h1234, 32'h5678}) begin
            n_err++; $display("FAIL dbz_hilo_kept: got %h expected 00001234_00005678", {hi, lo});
        end
    endtask

    task automatic test_start_while_busy;
        int lat;
        start = 1'b1; op = 2'b00; operand0 = 32'd6; operand1 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1; op = 2'b10; operand0 = 32'd9; operand1 = 32'd3;
        hi_wren = 1'b1; wdata = 32'hDEAD;
        @(posedge clk); #1;
        start = 1'b0; hi_wren = 1'b0;
        lat = 6;
        while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
        n_cmp++;
        if (lat !== 34) begin n_err++; $display("FAIL busy_start_latency: got %0d expected 34", lat); end
        n_cmp++;
        if ({hi, lo} !== {32'd0, 32'd42}) begin
            n_err++; $display("FAIL busy_start_result: got %h expected 00000000_0000002a", {hi, lo});
        end
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL no_queue: got busy %b expected 0", busy); end
    endtask

    task automatic test_reset_mid;
        int lat, bc; logic dz, ov; logic seen;
        start = 1'b1; op = 2'b11; operand0 = 32'hFFFF_FF9C; operand1 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, hi, lo} !== 65'h0) begin
            n_err++; $display("FAIL reset_mid: got %h expected 0", {busy, hi, lo});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (done) seen = 1'b1; end
        n_cmp++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL reset_no_done: got %b expected 0", seen); end
        run32(2'b10, 32'd100, 32'd7, lat, bc, dz, ov);
        n_cmp++;
        if ({hi, lo} !== {32'd2, 32'd14}) begin
            n_err++; $display("FAIL divu_after_reset: got %h expected 00000002_0000000e", {hi, lo});
        end
    endtask

    // Back-to-back: each new start is driven in the done cycle of the previous op.
    task automatic test_width8;
        logic [7:0] mhi, mlo, ehi, elo, ca, cb;
        logic [1:0] co;
        logic       edbz;
        int lat, elat, sa, sb, p, q, r;
        mhi = 8'h0; mlo = 8'h0;
        co = 2'b00; ca = 8'($urandom_range(0, 255)); cb = 8'($urandom_range(0, 255));
        start8 = 1'b1; op8 = co; operand0_8 = ca; operand1_8 = cb;
        for (int i = 0; i < 4000; i++) begin
            sa = ca[7] ? int'(ca) - 256 : int'(ca);
            sb = cb[7] ? int'(cb) - 256 : int'(cb);
            ehi = mhi; elo = mlo; edbz = 1'b0; elat = 10;
            case (co)
                2'b00: begin p = int'(ca) * int'(cb); {ehi, elo} = p[15:0]; end
                2'b01: begin p = sa * sb; {ehi, elo} = p[15:0]; end
                2'b10: begin
                    if (cb == 8'h0) begin edbz = 1'b1; elat = 2; end
                    else begin q = int'(ca) / int'(cb); r = int'(ca) % int'(cb);
                        elo = q[7:0]; ehi = r[7:0]; end
                end
                default: begin
                    if (cb == 8'h0) begin edbz = 1'b1; elat = 2; end
                    else begin q = sa / sb; r = sa % sb; elo = q[7:0]; ehi = r[7:0]; end
                end
            endcase
            @(posedge clk); #1;
            start8 = 1'b0;
            lat = 1;
            while (!done8 && lat < 30) begin @(posedge clk); #1; lat++; end
            n_cmp++;
            if (lat !== elat) begin
                n_err++; $display("FAIL w8_latency op%0d %h,%h: got %0d expected %0d", co, ca, cb, lat, elat);
            end
            n_cmp++;
            if ({hi8, lo8} !== {ehi, elo}) begin
                n_err++; $display("FAIL w8_result op%0d %h,%h: got %h expected %h", co, ca, cb,
                                  {hi8, lo8}, {ehi, elo});
            end
            n_cmp++;
            if (div_by_zero8 !== edbz) begin
                n_err++; $display("FAIL w8_dbz op%0d %h,%h: got %b expected %b", co, ca, cb,
                                  div_by_zero8, edbz);
            end
            mhi = ehi; mlo = elo;
            if (i < 3999) begin
                co = 2'((i + 1) % 4);
                ca = 8'($urandom_range(0, 255));
                cb = ($urandom_range(0, 15) == 0) ? 8'h0 : 8'($urandom_range(0, 255));
                start8 = 1'b1; op8 = co; operand0_8 = ca; operand1_8 = cb;
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; operand0 = '0; operand1 = '0;
        hi_wren = 1'b0; lo_wren = 1'b0; wdata = '0;
        start8 = 1'b0; op8 = 2'b00; operand0_8 = '0; operand1_8 = '0;
        hi_wren8 = 1'b0; lo_wren8 = 1'b0; wdata8 = '0;
        test_reset;
        test_mult;
        test_div_signed;
        test_div_by_zero;
        test_start_while_busy;
        test_reset_mid;
        test_width8;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
